clock_domain_import_fifo: RTL and testbench

Receiving stage of the toggle-handshake clock-domain crossing. It synchronises the remote `req` toggle, captures the word on `cdc_data`, queues it in a local FIFO, and returns `cdc_ack`. The ack is withheld while the FIFO is full, so the remote exporter stalls instead of losing data. It sits in the destination clock domain, directly downstream of the exporter, and feeds local consumers through a first-word-fall-through valid/pop port.

---
 rtl/clock_domain_import_fifo.sv | 81 ++++++++
 tb/tb_clock_domain_import_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_domain_import_fifo.sv
// Toggle-handshake CDC receiver: syncs cdc_req, queues cdc_data in a FWFT FIFO, returns cdc_ack.
// Optional `level` port enabled by defining CLOCK_DOMAIN_IMPORT_LEVEL_EN.
module clock_domain_import_fifo #(
    parameter int pBits  = 8,
    parameter int pDepth = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cdc_req,
    input  logic [pBits-1:0]                 cdc_data,
    output logic                             cdc_ack,
    output logic                             out_valid,
    output logic [pBits-1:0]                 out_data,
    input  logic                             out_pop
`ifdef CLOCK_DOMAIN_IMPORT_LEVEL_EN
    ,
    output logic [$clog2(pDepth+1)-1:0]      level
`endif
);

    localparam int PW = $clog2(pDepth);
    localparam int CW = $clog2(pDepth + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(pDepth);

    logic [1:0]       req_ff;
    logic             req_s;
    logic             pending;
    logic             full;
    logic             push;
    logic             pop;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [pBits-1:0] mem [pDepth];

    // req_ff[1] is the metastability stage; req_ff[0] is the settled value
    assign req_s   = req_ff[0];
    assign pending = (req_s != cdc_ack);
    assign full    = (count == FULL_CNT);
    assign push    = pending && !full;
    assign pop     = out_pop && out_valid;

    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

`ifdef CLOCK_DOMAIN_IMPORT_LEVEL_EN
    assign level = count;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ff  <= 2'b00;
            cdc_ack <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            req_ff <= {cdc_req, req_ff[1]};
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                cdc_ack <= req_s;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // cdc_data is stable for two cycles before req_s moves, so no synchroniser
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= cdc_data;
        end
    end

endmodule

// File: tb/tb_clock_domain_import_fifo.sv
// Directed table-driven bench for clock_domain_import_fifo.
// Level checks compile in when CLOCK_DOMAIN_IMPORT_LEVEL_EN is defined.
module tb_clock_domain_import_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       cdc_req;
    logic [7:0] cdc_data;
    logic       cdc_ack;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_pop;
`ifdef CLOCK_DOMAIN_IMPORT_LEVEL_EN
    logic [2:0] level;
`endif

    int checks = 0;
    int errors = 0;

    clock_domain_import_fifo #(.pBits(8), .pDepth(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .cdc_req  (cdc_req),
        .cdc_data (cdc_data),
        .cdc_ack  (cdc_ack),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_pop  (out_pop)
`ifdef CLOCK_DOMAIN_IMPORT_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic [7:0] data;
        logic       pop;
        logic       ack;
        logic       valid;
        logic [7:0] dout;
        logic [2:0] lvl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [7:0] d, logic p,
                                logic a, logic v, logic [7:0] o,
                                logic [2:0] l);
        vec_t t;
        t.req = r; t.data = d; t.pop = p;
        t.ack = a; t.valid = v; t.dout = o; t.lvl = l;
        return t;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_level(string name, logic [2:0] exp);
`ifdef CLOCK_DOMAIN_IMPORT_LEVEL_EN
        check(name, {29'd0, level}, {29'd0, exp});
`else
        if (exp > 3'd4) $display("bad level constant in %s", name);
`endif
    endtask

    task automatic send_word(logic r, logic [7:0] d);
        int n;
        cdc_req  = r;
        cdc_data = d;
        n = 0;
        while (n < 10 && cdc_ack !== r) begin
            tick();
            n++;
        end
        check("send_ack", {31'd0, cdc_ack}, {31'd0, r});
    endtask

    initial begin
        // single transfer
        vecs.push_back(mk(1, 8'hA5, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'hA5, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'hA5, 0, 1, 1, 8'hA5, 1));
        vecs.push_back(mk(1, 8'hA5, 1, 1, 0, 8'h00, 0));
        // fill and stall
        vecs.push_back(mk(0, 8'h01, 0, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'h01, 0, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'h01, 0, 0, 1, 8'h01, 1));
        vecs.push_back(mk(1, 8'h02, 0, 0, 1, 8'h01, 1));
        vecs.push_back(mk(1, 8'h02, 0, 0, 1, 8'h01, 1));
        vecs.push_back(mk(1, 8'h02, 0, 1, 1, 8'h01, 2));
        vecs.push_back(mk(0, 8'h03, 0, 1, 1, 8'h01, 2));
        vecs.push_back(mk(0, 8'h03, 0, 1, 1, 8'h01, 2));
        vecs.push_back(mk(0, 8'h03, 0, 0, 1, 8'h01, 3));
        vecs.push_back(mk(1, 8'h04, 0, 0, 1, 8'h01, 3));
        vecs.push_back(mk(1, 8'h04, 0, 0, 1, 8'h01, 3));
        vecs.push_back(mk(1, 8'h04, 0, 1, 1, 8'h01, 4));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 8'h05, 0, 1, 1, 8'h01, 4));
        vecs.push_back(mk(0, 8'h05, 1, 1, 1, 8'h02, 3));
        vecs.push_back(mk(0, 8'h05, 0, 0, 1, 8'h02, 4));
        vecs.push_back(mk(0, 8'h05, 1, 0, 1, 8'h03, 3));
        vecs.push_back(mk(0, 8'h05, 1, 0, 1, 8'h04, 2));
        vecs.push_back(mk(0, 8'h05, 1, 0, 1, 8'h05, 1));
        vecs.push_back(mk(0, 8'h05, 1, 0, 0, 8'h00, 0));
        // wrap-around
        vecs.push_back(mk(1, 8'h09, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h09, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h09, 0, 1, 1, 8'h09, 1));
        vecs.push_back(mk(0, 8'h0A, 0, 1, 1, 8'h09, 1));
        vecs.push_back(mk(0, 8'h0A, 0, 1, 1, 8'h09, 1));
        vecs.push_back(mk(0, 8'h0A, 0, 0, 1, 8'h09, 2));
        vecs.push_back(mk(1, 8'h0B, 0, 0, 1, 8'h09, 2));
        vecs.push_back(mk(1, 8'h0B, 0, 0, 1, 8'h09, 2));
        vecs.push_back(mk(1, 8'h0B, 0, 1, 1, 8'h09, 3));
        vecs.push_back(mk(1, 8'h0B, 1, 1, 1, 8'h0A, 2));
        // simultaneous push/pop at level 2
        vecs.push_back(mk(0, 8'h0C, 0, 1, 1, 8'h0A, 2));
        vecs.push_back(mk(0, 8'h0C, 0, 1, 1, 8'h0A, 2));
        vecs.push_back(mk(0, 8'h0C, 1, 0, 1, 8'h0B, 2));
        vecs.push_back(mk(0, 8'h0C, 1, 0, 1, 8'h0C, 1));
        vecs.push_back(mk(0, 8'h0C, 1, 0, 0, 8'h00, 0));
        // pop while empty
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 8'h0C, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h0D, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h0D, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h0D, 0, 1, 1, 8'h0D, 1));

        rst = 1'b1;
        cdc_req = 1'b0;
        cdc_data = 8'h00;
        out_pop = 1'b0;
        tick();
        tick();
        check("rst_ack", {31'd0, cdc_ack}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check_level("rst_level", 3'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            cdc_req  = vecs[i].req;
            cdc_data = vecs[i].data;
            out_pop  = vecs[i].pop;
            tick();
            check($sformatf("v%0d_ack", i),
                  {31'd0, cdc_ack}, {31'd0, vecs[i].ack});
            check($sformatf("v%0d_valid", i),
                  {31'd0, out_valid}, {31'd0, vecs[i].valid});
            if (vecs[i].valid)
                check($sformatf("v%0d_data", i),
                      {24'd0, out_data}, {24'd0, vecs[i].dout});
            check_level($sformatf("v%0d_level", i), vecs[i].lvl);
        end
        out_pop = 1'b0;

        // reset mid-operation with three words queued and req high
        send_word(1'b0, 8'h0E);
        send_word(1'b1, 8'h0F);
        check_level("pre_rst_level", 3'd3);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        cdc_data = 8'h5C;
        rst = 1'b1;
        tick();
        tick();
        check("mid_rst_ack", {31'd0, cdc_ack}, 32'd0);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_e1_ack", {31'd0, cdc_ack}, 32'd0);
        tick();
        check("post_rst_e2_ack", {31'd0, cdc_ack}, 32'd0);
        check("post_rst_e2_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("post_rst_e3_ack", {31'd0, cdc_ack}, 32'd1);
        check("post_rst_e3_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_e3_data", {24'd0, out_data}, 32'h5C);
        check_level("post_rst_level", 3'd1);
        out_pop = 1'b1;
        tick();
        out_pop = 1'b0;
        check("post_rst_pop_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_reimport_valid", {31'd0, out_valid}, 32'd0);
        end
        check("no_reimport_ack", {31'd0, cdc_ack}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
